// File: rtl/mlu_bootstrap_pkg.sv
// Shared MLU definitions: LUT geometry and the bootstrap writer state encoding.
// Optional feature macro: MLU_BOOTSTRAP_CHECKSUM_EN adds the CHECK and ERROR states.
package common;

    localparam int MLU_LUT_ADDR_W = 12;
    localparam int MLU_LUT_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
`ifdef MLU_BOOTSTRAP_CHECKSUM_EN
        ST_CHECK,
        ST_ERROR,
`endif
        ST_DONE
    } mlu_boot_state_t;

endpackage

// File: rtl/mlu_bootstrap_if.sv
// Bootstrap bus: incoming image byte stream plus the broadcast LUT write bus.
// The master side is the bootstrap writer; the slave side is the stream source / slices.
interface mlu_bootstrap_if
    import common::*;
#(
    parameter int ADDR_W = MLU_LUT_ADDR_W,
    parameter int DATA_W = MLU_LUT_DATA_W
);
    logic [DATA_W-1:0] IN_DATA;
    logic              IN_VALID;
    logic              IN_READY;
    logic [ADDR_W-1:0] BOOTSTRAP_ADDR;
    logic [DATA_W-1:0] BOOTSTRAP_DATA;
    logic              BOOTSTRAP_N_WE;
    logic              N_BOOTED;
    logic              ERROR;

    modport master (
        input  IN_DATA, IN_VALID,
        output IN_READY, BOOTSTRAP_ADDR, BOOTSTRAP_DATA, BOOTSTRAP_N_WE, N_BOOTED, ERROR
    );

    modport slave (
        output IN_DATA, IN_VALID,
        input  IN_READY, BOOTSTRAP_ADDR, BOOTSTRAP_DATA, BOOTSTRAP_N_WE, N_BOOTED, ERROR
    );
endinterface

// File: rtl/mlu_bootstrap.sv
// MLU LUT bootstrap writer: streams 2^ADDR_W bytes into all slice LUTs with a
// setup / strobe / hold write cycle per byte, then releases N_BOOTED.
// Optional feature macro: MLU_BOOTSTRAP_CHECKSUM_EN (trailer byte, mod-256 sum check, ERROR).
module mlu_bootstrap
    import common::*;
#(
    parameter int ADDR_W = MLU_LUT_ADDR_W,
    parameter int DATA_W = MLU_LUT_DATA_W
) (
    input  logic           CLK,
    input  logic           N_RST,
    mlu_bootstrap_if.master bus
);

    mlu_boot_state_t   state;
    mlu_boot_state_t   state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              take;

    // A byte is consumed only while waiting in FETCH
    assign take = (state == ST_FETCH) && bus.IN_VALID;

`ifdef MLU_BOOTSTRAP_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] sum_total;

    // Trailer is folded in combinationally; the image sum must cancel to zero
    assign sum_total = acc + bus.IN_DATA;

    // Running mod-2^DATA_W sum of accepted image bytes; stalled FETCH cycles do not count
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            acc <= '0;
        end else if (take) begin
            acc <= acc + bus.IN_DATA;
        end
    end
`endif

    // State register
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address counter and captured write data; address wraps to 0 after the last HOLD
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            addr <= '0;
            data <= '0;
        end else begin
            if (take) begin
                data <= bus.IN_DATA;
            end
            if (state == ST_HOLD) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = ST_FETCH;
            ST_FETCH:  if (bus.IN_VALID) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_STROBE;
            ST_STROBE: state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (addr != '1) begin
                    state_nxt = ST_FETCH;
                end else begin
`ifdef MLU_BOOTSTRAP_CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
`ifdef MLU_BOOTSTRAP_CHECKSUM_EN
            ST_CHECK: begin
                if (bus.IN_VALID) begin
                    state_nxt = (sum_total == '0) ? ST_DONE : ST_ERROR;
                end
            end
            ST_ERROR:  state_nxt = ST_ERROR;
`endif
            ST_DONE:   state_nxt = ST_DONE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded purely from the state register and the address/data registers
    always_comb begin
        bus.BOOTSTRAP_ADDR = addr;
        bus.BOOTSTRAP_DATA = data;
        bus.BOOTSTRAP_N_WE = (state != ST_STROBE);
        bus.N_BOOTED       = (state != ST_DONE);
`ifdef MLU_BOOTSTRAP_CHECKSUM_EN
        bus.IN_READY       = (state == ST_FETCH) || (state == ST_CHECK);
        bus.ERROR          = (state == ST_ERROR);
`else
        bus.IN_READY       = (state == ST_FETCH);
        bus.ERROR          = 1'b0;
`endif
    end

endmodule
